// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and its datapath.
// The datapath side (master) supplies run/instr/zero and receives the
// enables and mux selects that the controller produces.
interface mc_ctrl_if;
  logic        run;
  logic [31:0] instr;
  logic        zero;
  logic        pc_en;
  logic [1:0]  npc_sel;
  logic        ir_en;
  logic        rf_we;
  logic [1:0]  rf_wa_sel;
  logic [1:0]  rf_wd_sel;
  logic [2:0]  alu_op;
  logic        alu_b_sel;
  logic [1:0]  ext_op;
  logic        dm_we;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  modport master (
    output run, instr, zero,
    input  pc_en, npc_sel, ir_en, rf_we, rf_wa_sel, rf_wd_sel,
           alu_op, alu_b_sel, ext_op, dm_we, state, instr_cnt
  );

  modport slave (
    input  run, instr, zero,
    output pc_en, npc_sel, ir_en, rf_we, rf_wa_sel, rf_wd_sel,
           alu_op, alu_b_sel, ext_op, dm_we, state, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// combinational control decode from state and IR, retired-instruction count.
module mc_ctrl (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
  } kind_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  kind_t       kind;

  logic       pc_en, ir_en, rf_we, dm_we, alu_b_sel;
  logic [1:0] npc_sel, rf_wa_sel, rf_wd_sel, ext_op;
  logic [2:0] alu_op;

  // Register, shift-amount and immediate fields belong to the datapath.
  logic unused_fields;
  assign unused_fields = ^bus.instr[25:6];

  // Classify the IR into one instruction kind; anything unlisted is a no-op.
  always_comb begin
    kind = I_NOP;
    case (bus.instr[31:26])
      6'h00: begin
        case (bus.instr[5:0])
          6'h21:   kind = I_ADDU;
          6'h23:   kind = I_SUBU;
          6'h08:   kind = I_JR;
          default: kind = I_NOP;
        endcase
      end
      6'h0D:   kind = I_ORI;
      6'h0F:   kind = I_LUI;
      6'h23:   kind = I_LW;
      6'h2B:   kind = I_SW;
      6'h04:   kind = I_BEQ;
      6'h02:   kind = I_J;
      6'h03:   kind = I_JAL;
      default: kind = I_NOP;
    endcase
  end

  // State register; reset drops straight back to FETCH, aborting any instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Count an instruction as retired whenever the FSM returns to FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    cnt_q <= '0;
    else if (state_q != FETCH && state_d == FETCH) cnt_q <= cnt_q + 32'd1;
  end

  // Next-state and control outputs; everything defaults to 0 and reset masks all of it.
  always_comb begin
    state_d   = FETCH;
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    rf_we     = 1'b0;
    dm_we     = 1'b0;
    npc_sel   = 2'd0;
    rf_wa_sel = 2'd0;
    rf_wd_sel = 2'd0;
    alu_op    = 3'd0;
    alu_b_sel = 1'b0;
    ext_op    = 2'd0;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (kind)
          I_J: begin
            pc_en   = 1'b1;
            npc_sel = 2'd2;
          end
          I_JAL: begin
            pc_en     = 1'b1;
            npc_sel   = 2'd2;
            rf_we     = 1'b1;
            rf_wa_sel = 2'd2;
            rf_wd_sel = 2'd2;
          end
          I_JR: begin
            pc_en   = 1'b1;
            npc_sel = 2'd3;
          end
          I_NOP:   state_d = FETCH;
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (kind)
          I_BEQ: begin
            alu_op  = 3'd1;
            ext_op  = 2'd1;
            pc_en   = bus.zero;
            npc_sel = 2'd1;
          end
          I_ADDU: state_d = WB;
          I_SUBU: begin
            alu_op  = 3'd1;
            state_d = WB;
          end
          I_ORI: begin
            alu_op    = 3'd2;
            alu_b_sel = 1'b1;
            state_d   = WB;
          end
          I_LUI: begin
            alu_op    = 3'd3;
            alu_b_sel = 1'b1;
            state_d   = WB;
          end
          I_LW, I_SW: begin
            alu_b_sel = 1'b1;
            ext_op    = 2'd1;
            state_d   = MEM;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (kind == I_LW || kind == I_SW) begin
          alu_b_sel = 1'b1;
          ext_op    = 2'd1;
        end
        if (kind == I_SW) dm_we = 1'b1;
        if (kind == I_LW) state_d = WB;
      end
      WB: begin
        case (kind)
          I_ADDU, I_SUBU: begin
            rf_we     = 1'b1;
            rf_wa_sel = 2'd1;
          end
          I_ORI, I_LUI: rf_we = 1'b1;
          I_LW: begin
            rf_we     = 1'b1;
            rf_wd_sel = 2'd1;
          end
          default: rf_we = 1'b0;
        endcase
      end
      default: state_d = FETCH;
    endcase
    if (!rst) begin
      pc_en     = 1'b0;
      ir_en     = 1'b0;
      rf_we     = 1'b0;
      dm_we     = 1'b0;
      npc_sel   = 2'd0;
      rf_wa_sel = 2'd0;
      rf_wd_sel = 2'd0;
      alu_op    = 3'd0;
      alu_b_sel = 1'b0;
      ext_op    = 2'd0;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ir_en     = ir_en;
  assign bus.rf_we     = rf_we;
  assign bus.dm_we     = dm_we;
  assign bus.npc_sel   = npc_sel;
  assign bus.rf_wa_sel = rf_wa_sel;
  assign bus.rf_wd_sel = rf_wd_sel;
  assign bus.alu_op    = alu_op;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.ext_op    = ext_op;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed instruction sequences followed by random
// instruction streams, each compared cycle by cycle with a per-instruction
// reference table of expected control words.
module tb_mc_ctrl;

  logic clk;
  logic rst;
  mc_ctrl_if bus ();

  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_en;
    logic       ir_en;
    logic       rf_we;
    logic       dm_we;
    logic [1:0] npc;
    logic [1:0] wa;
    logic [1:0] wd;
    logic [2:0] alu;
    logic       b;
    logic [1:0] ext;
  } ctl_t;

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5,
                 K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] model_cnt = 0;
  ctl_t        exp_q[$];

  // Mnemonic of an instruction word, straight from the opcode/funct table.
  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      return K_NOP;
    end
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    return K_NOP;
  endfunction

  function automatic ctl_t blank(input logic [2:0] s);
    ctl_t c;
    c    = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.st    = bus.state;
    c.pc_en = bus.pc_en;
    c.ir_en = bus.ir_en;
    c.rf_we = bus.rf_we;
    c.dm_we = bus.dm_we;
    c.npc   = bus.npc_sel;
    c.wa    = bus.rf_wa_sel;
    c.wd    = bus.rf_wd_sel;
    c.alu   = bus.alu_op;
    c.b     = bus.alu_b_sel;
    c.ext   = bus.ext_op;
    return c;
  endfunction

  // Expected control word for every cycle of one instruction, fetch first.
  task automatic build_expect(input logic [31:0] ins, input logic z);
    int   k;
    ctl_t c;
    k = classify(ins);
    exp_q.delete();
    c = blank(3'd0); c.pc_en = 1'b1; c.ir_en = 1'b1; exp_q.push_back(c);
    c = blank(3'd1);
    if (k == K_J)   begin c.pc_en = 1'b1; c.npc = 2'd2; end
    if (k == K_JAL) begin c.pc_en = 1'b1; c.npc = 2'd2; c.rf_we = 1'b1; c.wa = 2'd2; c.wd = 2'd2; end
    if (k == K_JR)  begin c.pc_en = 1'b1; c.npc = 2'd3; end
    exp_q.push_back(c);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_NOP) return;
    c = blank(3'd2);
    case (k)
      K_BEQ:      begin c.alu = 3'd1; c.ext = 2'd1; c.pc_en = z; c.npc = 2'd1; end
      K_ADDU:     c.alu = 3'd0;
      K_SUBU:     c.alu = 3'd1;
      K_ORI:      begin c.alu = 3'd2; c.b = 1'b1; end
      K_LUI:      begin c.alu = 3'd3; c.b = 1'b1; end
      K_LW, K_SW: begin c.alu = 3'd0; c.b = 1'b1; c.ext = 2'd1; end
      default:    c = blank(3'd2);
    endcase
    exp_q.push_back(c);
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      c = blank(3'd3); c.b = 1'b1; c.ext = 2'd1; c.dm_we = (k == K_SW);
      exp_q.push_back(c);
      if (k == K_SW) return;
    end
    c = blank(3'd4);
    c.rf_we = 1'b1;
    c.wa    = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    c.wd    = (k == K_LW) ? 2'd1 : 2'd0;
    exp_q.push_back(c);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one instruction from FETCH to its return to FETCH, checking every cycle.
  task automatic applyStimulus(input string name, input logic [31:0] ins, input logic z,
                               input bit drop_run);
    build_expect(ins, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.run   = (i == 0) ? 1'b1 : ~drop_run;
      bus.instr = ins;
      bus.zero  = z;
      #1;
      if (i == 0) checkOutput({name, "_cnt"}, bus.instr_cnt, model_cnt);
      checkOutput($sformatf("%s_c%0d", name, i), 32'(sample()), 32'(exp_q[i]));
    end
    model_cnt = model_cnt + 32'd1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] base;
    base = $urandom();
    case ($urandom_range(0, 11))
      0:       return {6'h00, base[25:6], 6'h21};
      1:       return {6'h00, base[25:6], 6'h23};
      2:       return {6'h00, base[25:6], 6'h08};
      3:       return {6'h0D, base[25:0]};
      4:       return {6'h0F, base[25:0]};
      5:       return {6'h23, base[25:0]};
      6:       return {6'h2B, base[25:0]};
      7:       return {6'h04, base[25:0]};
      8:       return {6'h02, base[25:0]};
      9:       return {6'h03, base[25:0]};
      10:      return {6'h00, base[25:6], 6'h2A};
      default: return {6'h08, base[25:0]};
    endcase
  endfunction

  initial begin
    rst       = 1'b0;
    bus.run   = 1'b1;
    bus.instr = 32'h0;
    bus.zero  = 1'b0;

    // Held in reset with run high: FETCH, count 0, nothing enabled.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ctl", 32'(sample()), 32'(blank(3'd0)));
    checkOutput("reset_cnt", bus.instr_cnt, 32'd0);

    // Released with run low: stays idle in FETCH.
    @(negedge clk);
    rst     = 1'b1;
    bus.run = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("idle_ctl", 32'(sample()), 32'(blank(3'd0)));
    end

    // Back-to-back nops, then the directed instruction set.
    for (int i = 0; i < 3; i++) applyStimulus("nop", 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus("addu", 32'h0022_1821, 1'b0, 1'b0);
    applyStimulus("lw",   32'h8C22_0004, 1'b0, 1'b0);
    applyStimulus("sw",   32'hAC22_0008, 1'b0, 1'b0);
    applyStimulus("beq1", 32'h1022_0003, 1'b1, 1'b0);
    applyStimulus("beq0", 32'h1022_0003, 1'b0, 1'b0);
    applyStimulus("jal",  32'h0C00_0010, 1'b0, 1'b0);
    applyStimulus("jr",   32'h03E0_0008, 1'b0, 1'b0);
    applyStimulus("ori",  32'h3422_FFFF, 1'b0, 1'b1);
    applyStimulus("lui",  32'h3C01_1234, 1'b0, 1'b1);
    applyStimulus("subu", 32'h0022_1823, 1'b0, 1'b1);
    applyStimulus("j",    32'h0800_0040, 1'b0, 1'b0);

    // Random instruction stream, run randomly dropped mid-instruction.
    for (int i = 0; i < 60; i++)
      applyStimulus($sformatf("rnd%0d", i), rand_instr(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));

    // Reset arrives asynchronously while a lw sits in MEM.
    build_expect(32'h8C22_0004, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.run   = 1'b1;
      bus.instr = 32'h8C22_0004;
      #1;
      checkOutput($sformatf("lwabort_c%0d", i), 32'(sample()), 32'(exp_q[i]));
    end
    #1 rst = 1'b0;
    #1;
    model_cnt = 0;
    checkOutput("abort_state", 32'(bus.state), 32'd0);
    checkOutput("abort_cnt", bus.instr_cnt, model_cnt);
    checkOutput("abort_ctl", 32'(sample()), 32'(blank(3'd0)));
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("abort_hold", 32'(sample()), 32'(blank(3'd0)));
    end
    @(negedge clk);
    rst     = 1'b1;
    bus.run = 1'b0;
    #1;
    checkOutput("abort_release", 32'(sample()), 32'(blank(3'd0)));
    @(negedge clk);
    #1;
    checkOutput("abort_norwb", 32'(sample()), 32'(blank(3'd0)));
    checkOutput("abort_cnt2", bus.instr_cnt, model_cnt);

    // First fetch after reset happens on the first edge with run high.
    applyStimulus("postrst", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    bus.run = 1'b0;
    #1;
    checkOutput("final_ctl", 32'(sample()), 32'(blank(3'd0)));
    checkOutput("final_cnt", bus.instr_cnt, model_cnt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have the port `clk`, an input of width 1: the system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `rst`, an input of width 1: asynchronous, active-low reset.
REQ-003 The block SHALL have the port `run`, an input of width 1: when high, a new instruction fetch may start.
REQ-004 The block SHALL have the port `instr`, an input of width 32: IR contents, stable from DECODE onward.
REQ-005 The block SHALL have the port `zero`, an input of width 1: ALU equality flag, valid in EXEC.
REQ-006 The block SHALL have the port `pc_en`, an output of width 1: PC register write enable.
REQ-007 The block SHALL have the port `npc_sel`, an output of width 2, encoded as follows.
- 0 = PC+4
- 1 = branch target
- 2 = j/jal target
- 3 = GPR[rs]
REQ-008 The block SHALL have the port `ir_en`, an output of width 1: IR write enable.
REQ-009 The block SHALL have the port `rf_we`, an output of width 1: register file write enable.
REQ-010 The block SHALL have the port `rf_wa_sel`, an output of width 2: write address select (0 = rt, 1 = rd, 2 = $31).
REQ-011 The block SHALL have the port `rf_wd_sel`, an output of width 2: write data select (0 = ALU, 1 = DM, 2 = PC).
REQ-012 The block SHALL have the port `alu_op`, an output of width 3, encoded as follows.
- 0 = add
- 1 = sub
- 2 = or
- 3 = lui
REQ-013 The block SHALL have the port `alu_b_sel`, an output of width 1: ALU B operand select (0 = GPR[rt], 1 = extended immediate).
REQ-014 The block SHALL have the port `ext_op`, an output of width 2: immediate extension (0 = zero-extend, 1 = sign-extend).
REQ-015 The block SHALL have the port `dm_we`, an output of width 1: data memory write enable.
REQ-016 The block SHALL have the port `state`, an output of width 3: current FSM state.
REQ-017 The block SHALL have the port `instr_cnt`, an output of width 32: count of retired instructions.

Function
REQ-018 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3 and WB=4; encodings 5–7 SHALL transition to FETCH on the next edge.
REQ-019 In FETCH with run=1, the block SHALL assert ir_en=1, pc_en=1 and npc_sel=0, and the next state SHALL be DECODE.
REQ-020 In FETCH with run=0, all enables SHALL be 0 and the FSM SHALL stay in FETCH.
REQ-021 In DECODE, instructions SHALL be decoded from instr[31:26] and, for opcode 0, from funct instr[5:0].
REQ-022 The supported instructions SHALL be: addu (0/21), subu (0/23), jr (0/08), ori (0D), lui (0F), lw (23), sw (2B), beq (04), j (02), jal (03).
REQ-023 In DECODE, j SHALL assert pc_en=1 with npc_sel=2, and the next state SHALL be FETCH.
REQ-024 In DECODE, jal SHALL assert pc_en=1, npc_sel=2, rf_we=1, rf_wa_sel=2 and rf_wd_sel=2, and the next state SHALL be FETCH.
- Because PC already holds PC+4, $31 receives PC+4.
REQ-025 In DECODE, jr SHALL assert pc_en=1 with npc_sel=3, and the next state SHALL be FETCH.
REQ-026 In DECODE, any opcode/funct not listed in REQ-022 (including nop 0x00000000) SHALL be treated as a no-op and the next state SHALL be FETCH.
- In that cycle rf_we=0 and dm_we=0.
REQ-027 From DECODE, all other supported instructions SHALL go to EXEC.
REQ-028 In EXEC, beq SHALL drive alu_op=1, alu_b_sel=0, ext_op=1, pc_en=zero and npc_sel=1, and the next state SHALL be FETCH.
REQ-029 In EXEC, addu/subu SHALL drive alu_op=0/1 respectively with alu_b_sel=0, and the next state SHALL be WB.
REQ-030 In EXEC, ori SHALL drive alu_op=2, alu_b_sel=1 and ext_op=0, and the next state SHALL be WB.
REQ-031 In EXEC, lui SHALL drive alu_op=3 and alu_b_sel=1, and the next state SHALL be WB.
REQ-032 In EXEC, lw/sw SHALL drive alu_op=0, alu_b_sel=1 and ext_op=1, and the next state SHALL be MEM.
REQ-033 In MEM, sw SHALL assert dm_we=1 and the next state SHALL be FETCH.
REQ-034 In MEM, lw SHALL keep the address stable, and the next state SHALL be WB.
REQ-035 In WB, the block SHALL assert rf_we=1, and the next state SHALL be FETCH.
- addu/subu: rf_wa_sel=1, rf_wd_sel=0.
- ori/lui: rf_wa_sel=0, rf_wd_sel=0.
- lw: rf_wa_sel=0, rf_wd_sel=1.
REQ-036 The per-instruction cycle counts SHALL be: j/jal/jr/unknown 2; beq 3; sw/addu/subu/ori/lui 4; lw 5.
REQ-037 In any state/instruction combination not explicitly enabled above, all enables (pc_en, ir_en, rf_we, dm_we) SHALL be 0.
- Select outputs are then don't-care but SHALL be driven to 0.
REQ-038 Control outputs SHALL be combinational functions of state and instr only, with no extra register stage.
REQ-039 instr_cnt SHALL increment by 1 on every transition into FETCH from any non-FETCH state, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-040 run SHALL be sampled only in FETCH; deasserting run mid-instruction SHALL not stall the instruction, which completes normally.

Reset
REQ-041 While rst=0, the block SHALL immediately (asynchronously) force state=FETCH and instr_cnt=0.
REQ-042 While rst=0, all enable outputs SHALL be 0 regardless of run.
REQ-043 Reset asserted mid-instruction SHALL abort that instruction with no further writes, and that instruction SHALL not be counted.
REQ-044 After rst rises, the first fetch SHALL occur on the first rising edge at which run=1.

Verification
REQ-045 Bench: reset then run=1, instr=0x00000000 -> state sequence 0,1,0,1…; pc_en pulses only in FETCH; instr_cnt=3 after 6 cycles.
REQ-046 Bench: addu $3,$1,$2 (0x00221821) -> 4 cycles; rf_we=1 only in WB with rf_wa_sel=1; alu_op=0 in EXEC; instr_cnt +1.
REQ-047 Bench: lw (0x8C220004) then sw (0xAC220008) -> 5 and 4 cycles; dm_we=1 exactly one cycle (sw MEM); rf_wd_sel=1 in lw WB.
REQ-048 Bench: beq (0x10220003) with zero=1, then with zero=0 -> EXEC pc_en=1/npc_sel=1 vs pc_en=0; both return to FETCH after 3 cycles.
REQ-049 Bench: jal (0x0C000010) -> DECODE has pc_en=1, npc_sel=2, rf_we=1, rf_wa_sel=2, rf_wd_sel=2; then jr $31 (0x03E00008) -> npc_sel=3.
REQ-050 Bench: assert rst=0 asynchronously during lw MEM -> state=0 and instr_cnt=0 before the next edge; no rf_we pulse follows.
